// File: rtl/pwm_array.sv
// Multi-channel PWM generator with its own period counter.
// Left-aligned (sawtooth) or center-aligned (triangle), shadowed duty.
module pwm_array #(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        hsync,
    input  logic [CHANNELS*WIDTH-1:0]   data,
    input  logic                        center_mode,
    output logic [CHANNELS-1:0]         out,
    output logic                        period_done
);

    localparam logic [WIDTH-1:0] MAX = '1;
    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);
    localparam logic             UP  = 1'b0;
    localparam logic             DN  = 1'b1;

    logic [WIDTH-1:0] cnt;
    logic [WIDTH-1:0] cnt_nxt;
    logic [WIDTH-1:0] duty [CHANNELS];
    logic             mode;
    logic             dir;
    logic             dir_nxt;
    logic             hsync_d;
    logic             run;
    logic             rise;
    logic             steady;
    logic             boundary;

    assign rise   = hsync & ~hsync_d;
    assign steady = hsync & hsync_d & run;

    // Last count of a period: the next count is the period start.
    assign boundary = mode ? ((cnt == ONE) && (dir == DN))
                           : (cnt == MAX);

    always_comb begin
        cnt_nxt = cnt;
        dir_nxt = dir;
        if (boundary) begin
            cnt_nxt = '0;
            dir_nxt = UP;
        end else if (!mode) begin
            cnt_nxt = cnt + ONE;
        end else if (dir == UP) begin
            if (cnt == MAX) begin
                cnt_nxt = MAX - ONE;
                dir_nxt = DN;
            end else begin
                cnt_nxt = cnt + ONE;
            end
        end else begin
            cnt_nxt = cnt - ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt         <= '0;
            mode        <= 1'b0;
            dir         <= UP;
            hsync_d     <= 1'b0;
            run         <= 1'b0;
            out         <= '0;
            period_done <= 1'b0;
            for (int i = 0; i < CHANNELS; i++) begin
                duty[i] <= '0;
            end
        end else begin
            hsync_d     <= hsync;
            period_done <= steady & boundary;
            for (int i = 0; i < CHANNELS; i++) begin
                out[i] <= hsync & run & (cnt < duty[i]);
            end

            unique case (1'b1)
                rise: begin
                    cnt  <= '0;
                    dir  <= UP;
                    mode <= center_mode;
                    run  <= 1'b1;
                    for (int i = 0; i < CHANNELS; i++) begin
                        duty[i] <= data[i*WIDTH +: WIDTH];
                    end
                end
                !hsync: begin
                    run <= 1'b0;
                    cnt <= '0;
                    dir <= UP;
                end
                steady: begin
                    cnt <= cnt_nxt;
                    dir <= dir_nxt;
                    // New duty and mode take effect from cnt=0.
                    if (boundary) begin
                        mode <= center_mode;
                        for (int i = 0; i < CHANNELS; i++) begin
                            duty[i] <= data[i*WIDTH +: WIDTH];
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_pwm_array.sv
// Randomised bench for pwm_array against a period-position model,
// plus directed waveform measurements pinned to literal values.
module tb_pwm_array;

    localparam int W   = 8;
    localparam int CH  = 4;
    localparam int MAX = (1 << W) - 1;

    logic            clk = 1'b0;
    logic            rst;
    logic            hsync;
    logic [CH*W-1:0] data;
    logic            center_mode;
    logic [CH-1:0]   out;
    logic            period_done;

    int errors = 0;
    int checks = 0;
    int shown  = 0;

    pwm_array #(.WIDTH(W), .CHANNELS(CH)) dut (
        .clk         (clk),
        .rst         (rst),
        .hsync       (hsync),
        .data        (data),
        .center_mode (center_mode),
        .out         (out),
        .period_done (period_done)
    );

    always #5 clk = ~clk;

    // Model: position within the period, counter derived from it.
    function automatic int period_of(input bit md);
        return md ? 2 * MAX : MAX + 1;
    endfunction

    function automatic int cnt_of(input int pos, input bit md);
        if (!md) return pos;
        return (pos <= MAX) ? pos : 2 * MAX - pos;
    endfunction

    bit          started = 0;
    bit          m_act   = 0;
    bit          m_mode  = 0;
    bit          m_hprev = 0;
    int          m_pos   = 0;
    int          m_duty [CH];
    logic [CH-1:0] e_out = '0;
    logic          e_pd  = 1'b0;

    always @(posedge clk) begin
        bit rise;
        if (rst) begin
            started = 1;
            m_act   = 0;
            m_mode  = 0;
            m_hprev = 0;
            m_pos   = 0;
            for (int i = 0; i < CH; i++) m_duty[i] = 0;
            e_out = '0;
            e_pd  = 1'b0;
        end else begin
            rise = hsync && !m_hprev;
            for (int i = 0; i < CH; i++)
                e_out[i] = hsync && m_act &&
                           (cnt_of(m_pos, m_mode) < m_duty[i]);
            e_pd = hsync && m_act && !rise &&
                   (m_pos == period_of(m_mode) - 1);
            if (rise || (hsync && m_act &&
                         m_pos == period_of(m_mode) - 1)) begin
                m_act  = 1;
                m_pos  = 0;
                m_mode = center_mode;
                for (int i = 0; i < CH; i++)
                    m_duty[i] = int'(data[i*W +: W]);
            end else if (!hsync) begin
                m_act = 0;
                m_pos = 0;
            end else if (m_act) begin
                m_pos = m_pos + 1;
            end
            m_hprev = hsync;
        end
    end

    always @(negedge clk) begin
        if (started) begin
            checks++;
            if (out !== e_out || period_done !== e_pd) begin
                errors++;
                if (shown < 10) begin
                    shown++;
                    $display("FAIL cycle t=%0t out=%b pd=%b need out=%b pd=%b",
                             $time, out, period_done, e_out, e_pd);
                end
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic wait_pd();
        for (int i = 0; i < 1100; i++) begin
            @(negedge clk);
            if (period_done === 1'b1) return;
        end
        chk("pd_timeout", 0, 1);
    endtask

    int mlen;
    int mhi [CH];

    // Counts one period window: samples after a pulse up to the next.
    task automatic measure(input int chg_at, input logic [CH*W-1:0] nd,
                           input logic nm);
        mlen = 0;
        for (int c = 0; c < CH; c++) mhi[c] = 0;
        while (mlen < 1100) begin
            @(negedge clk);
            mlen++;
            for (int c = 0; c < CH; c++) mhi[c] += int'(out[c]);
            if (mlen == chg_at) begin
                data        = nd;
                center_mode = nm;
            end
            if (period_done === 1'b1) break;
        end
    endtask

    function automatic logic [W-1:0] rnd_duty();
        case ($urandom_range(4))
            0: return '0;
            1: return W'(MAX);
            2: return W'(1);
            default: return W'($urandom_range(MAX));
        endcase
    endfunction

    logic [CH*W-1:0] base;

    initial begin
        base        = {8'd128, 8'd255, 8'd0, 8'd20};
        rst         = 1'b1;
        hsync       = 1'b1;
        data        = 32'hA5C3_F00F;
        center_mode = 1'b0;
        @(negedge clk);
        chk("reset_out", int'(out), 0);
        chk("reset_pd", int'(period_done), 0);
        repeat (2) @(negedge clk);

        data = base;
        rst  = 1'b0;
        @(negedge clk);
        chk("rise_edge_out", int'(out), 0);
        @(negedge clk);
        chk("first_out", int'(out), 4'b1101);
        wait_pd();
        measure(0, base, 1'b0);
        chk("left_len", mlen, 256);
        chk("left_ch0", mhi[0], 20);
        chk("left_ch1", mhi[1], 0);
        chk("left_ch2", mhi[2], 255);
        chk("left_ch3", mhi[3], 128);

        center_mode = 1'b1;
        wait_pd();
        measure(0, base, 1'b1);
        chk("center_len", mlen, 510);
        chk("center_ch0", mhi[0], 39);
        chk("center_ch1", mhi[1], 0);
        chk("center_ch2", mhi[2], 509);
        chk("center_ch3", mhi[3], 255);

        center_mode = 1'b0;
        wait_pd();
        measure(50, {base[31:8], 8'd100}, 1'b1);
        chk("chg_cur_len", mlen, 256);
        chk("chg_cur_ch0", mhi[0], 20);
        measure(0, {base[31:8], 8'd100}, 1'b1);
        chk("chg_next_len", mlen, 510);
        chk("chg_next_ch0", mhi[0], 199);

        data        = base;
        center_mode = 1'b0;
        wait_pd();
        repeat (100) @(negedge clk);
        hsync = 1'b0;
        @(negedge clk);
        chk("drop_out", int'(out), 0);
        chk("drop_pd", int'(period_done), 0);
        repeat (9) @(negedge clk);
        hsync = 1'b1;
        wait_pd();
        measure(0, base, 1'b0);
        chk("resume_len", mlen, 256);
        chk("resume_ch0", mhi[0], 20);

        repeat (200) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_out", int'(out), 0);
        rst   = 1'b0;
        hsync = 1'b0;
        @(negedge clk);
        hsync = 1'b1;
        wait_pd();
        measure(0, base, 1'b0);
        chk("rst_resume_len", mlen, 256);
        chk("rst_resume_ch0", mhi[0], 20);

        for (int n = 0; n < 20000; n++) begin
            @(negedge clk);
            rst = ($urandom_range(2999) == 0);
            if ($urandom_range(399) == 0) hsync = ~hsync;
            if ($urandom_range(7) == 0)
                for (int c = 0; c < CH; c++) data[c*W +: W] = rnd_duty();
            if ($urandom_range(299) == 0) center_mode = ~center_mode;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pwm_array.md
Name: pwm_array

Overview:
- Multi-channel, parametrised successor to the single-channel, 8-bit PWM block driven by the external global counter.
- Owns its own period counter, so no external counter is needed.
- Latches per-channel duty values into shadow registers at line start (hsync rising edge) and at every period boundary.
- Supports left-aligned (sawtooth) and center-aligned (triangle) modulation; sits between the line-timing logic and the LED/backlight drivers.

Parameters:
- WIDTH, 8: duty/counter width in bits; MAX = 2^WIDTH-1.
- CHANNELS, 4: number of independent PWM outputs.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- hsync  input  1  line-active gate; PWM runs only while high.
- data  input  CHANNELS*WIDTH  duty values; channel i = data[i*WIDTH +: WIDTH].
- center_mode  input  1  0 = left-aligned, 1 = center-aligned; sampled with duty.
- out  output  CHANNELS  registered PWM outputs.
- period_done  output  1  one-cycle pulse on the last count of each period.

Behaviour:
- Reset (rst=1 at a clock edge) clears the following, and takes priority over everything, mid-period included:
  - cnt, all duty shadows, mode, direction (up), hsync_d, run: all to 0.
  - out and period_done: both 0.
- hsync_d is hsync registered; a rise is hsync=1 while hsync_d=0.
- Rise edge:
  - cnt<=0, dir<=up.
  - Every duty[i]<=data slice, mode<=center_mode.
  - run<=1.
- While hsync=0:
  - run<=0, cnt<=0, dir<=up.
  - out<=0 and period_done<=0 on the following edge.
  - Duty shadows hold their values.
- Left mode counting (while run=1 and no rise): cnt increments 0..MAX and wraps to 0. Period = 2^WIDTH cycles.
- Center mode counting:
  - cnt counts up 0..MAX, then down MAX-1..0, then up again.
  - dir flips when cnt reaches MAX going up (next value MAX-1) and when it reaches 0 going down.
  - Period = 2*MAX cycles (510 for WIDTH=8).
- Boundary: the cycle where the next cnt returns to the period start.
  - Left mode: cnt==MAX.
  - Center mode: cnt==1 with dir=down.
- At a boundary:
  - period_done<=1 for one cycle.
  - Duty shadows and mode reload from data/center_mode, taking effect from cnt=0.
  - A mode change restarts with cnt=0, dir=up.
- Output: out[i]<=run && (cnt < duty[i]), evaluated on registered cnt/duty; out lags cnt by exactly one clock.
- Duty extremes:
  - duty=0 gives out constantly 0.
  - duty=MAX, left mode: low for exactly 1 cycle per period.
  - duty=MAX, center mode: low for exactly 1 cycle per period (at cnt=MAX).
- High time per period:
  - Left mode: duty cycles.
  - Center mode: 2*duty-1 cycles for duty≥1, centred on cnt=0.
- data changes mid-period are ignored until the next boundary or rise; there is no glitching.
- Simultaneous rise and boundary: rise wins, with the same reload values, so the result is identical.
- hsync falling mid-period aborts the period; no period_done is issued.
- Arithmetic is unsigned. Comparisons are WIDTH bits; no extension is needed because cnt ≤ MAX.

Test Plan:
- Reset with hsync high and data nonzero → out=0 and period_done=0 the cycle after rst; outputs start only after rst low and a fresh hsync rise (requires hsync_d=0 after reset, so a rise is detected on the first cycle).
- Left mode, WIDTH=8, ch0=20, ch1=0, ch2=255, ch3=128, hsync rise → out[0] high 20 of every 256 cycles starting one clock after the rise; out[1] never high; out[2] low exactly 1 cycle per period; out[3] high 128; period_done pulses every 256 cycles.
- Center mode, ch0=20 → period 510; out[0] high 39 contiguous cycles spanning the period start; period_done every 510 cycles.
- Change ch0 from 20 to 100 at cnt=50 → current period keeps 20 high cycles; the next period shows 100; center_mode toggled mid-period takes effect only at the boundary.
- hsync low at cnt=100, then high 10 cycles later → out drops to 0 one clock later with no period_done; the new rise restarts cnt=0 and reloads duty.
- rst asserted at cnt=200 while running → next cycle out=0; rst deasserted, then hsync cycled → normal 20/256 waveform resumes.
